// File: rtl/wdma_sched_pkg.sv
`default_nettype none
// ============================================================================
// wdma_sched_pkg : shared types and constants for the WDMA buffer scheduler
// Revision 1.0
// ============================================================================
package wdma_sched_pkg;

    localparam int QDEPTH_DEFAULT = 2;
    localparam int DESC_W         = 40;

    localparam int ST_RUNNING  = 0;
    localparam int ST_UNDERRUN = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_STOPPED  = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_ACTIVE   = 2'd2,
        S_IRQ_WAIT = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/wdma_desc_fifo.sv
`default_nettype none
// ============================================================================
// wdma_desc_fifo : descriptor FIFO with push/pop/flush, flush dominates
// Revision 1.0
// ============================================================================
module wdma_desc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full queue is still accepted.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/wdma_buf_scheduler.sv
`default_nettype none
// ============================================================================
// wdma_buf_scheduler : queues host buffer descriptors and launches the write engine
// Revision 1.0
// ============================================================================
module wdma_buf_scheduler
    import wdma_sched_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid_i,
    input  logic [31:0] desc_addr_i,
    input  logic [7:0]  desc_up_addr_i,
    input  logic        run_start_i,
    input  logic        run_stop_i,
    input  logic        irq_dis_i,
    output logic        eng_start_o,
    output logic [31:0] eng_addr_o,
    output logic [7:0]  eng_up_addr_o,
    input  logic        eng_done_i,
    output logic        irq_req_o,
    input  logic        irq_ack_i,
    output logic [15:0] buf_ptr_o,
    output logic [3:0]  status_o,
    output logic        desc_full_o
);
    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              run;
    logic              underrun;
    logic              overflow;
    logic              stopped;
    logic [DESC_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              launch_go;
    logic              to_idle;

    assign pop = (state == S_LAUNCH);
    // A stop in the same cycle flushes the queue, so it must also veto a launch.
    assign launch_go = (state == S_IDLE) && run && !fifo_empty && !run_stop_i;
    assign to_idle   = ((state == S_ACTIVE) && eng_done_i && irq_dis_i) ||
                       ((state == S_IRQ_WAIT) && irq_ack_i);

    wdma_desc_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (desc_valid_i),
        .pop   (pop),
        .flush (run_stop_i),
        .din   ({desc_up_addr_i, desc_addr_i}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (launch_go) state_nxt = S_LAUNCH;
            S_LAUNCH:   state_nxt = S_ACTIVE;
            S_ACTIVE:   if (eng_done_i) state_nxt = irq_dis_i ? S_IDLE : S_IRQ_WAIT;
            S_IRQ_WAIT: if (irq_ack_i) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        eng_start_o = (state == S_LAUNCH);
        irq_req_o   = (state == S_IRQ_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_addr_o    <= '0;
            eng_up_addr_o <= '0;
            buf_ptr_o     <= '0;
            run           <= 1'b0;
            underrun      <= 1'b0;
            overflow      <= 1'b0;
            stopped       <= 1'b0;
        end else begin
            // Address is captured on entry to LAUNCH so it is valid with the start pulse.
            if (launch_go) {eng_up_addr_o, eng_addr_o} <= head;
            if ((state == S_ACTIVE) && eng_done_i) buf_ptr_o <= buf_ptr_o + 16'd1;

            if (run_stop_i)       run <= 1'b0;
            else if (run_start_i) run <= 1'b1;

            if (run_stop_i)       stopped <= 1'b1;
            else if (run_start_i) stopped <= 1'b0;

            if (desc_valid_i && fifo_full && !pop) overflow <= 1'b1;
            else if (run_start_i)                  overflow <= 1'b0;

            if (to_idle && run && !run_stop_i && fifo_empty) underrun <= 1'b1;
            else if (run_start_i)                            underrun <= 1'b0;
        end
    end

    always_comb begin
        status_o              = '0;
        status_o[ST_RUNNING]  = run;
        status_o[ST_UNDERRUN] = underrun;
        status_o[ST_OVERFLOW] = overflow;
        status_o[ST_STOPPED]  = stopped;
    end

    assign desc_full_o = fifo_full;

endmodule
`default_nettype wire
